ifetch_seq: RTL and testbench

- Instruction fetch sequencer on the producer side of the front-end instruction aligner.
- Owns the fetch PC and issues 8-byte-aligned 64-bit SRAM reads.
- Handles jump/branch redirects, decode stalls and 32-bit instructions that straddle a doubleword boundary.
- Presents pc, the 64-bit fetch word, jb_ff and sram_cs_ff to the aligner, which returns isrv16 for the PC increment.

---
 rtl/ifetch_seq.sv | 162 ++++++++++++++++
 tb/tb_ifetch_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_seq
// Brief    : Instruction fetch sequencer. Owns the fetch PC, issues 8-byte
//            aligned 64-bit SRAM reads (1-cycle latency), and handles
//            redirects, decode stalls and doubleword-straddling instructions.
//            Optional macro IFETCH_HOLD_BUF_EN adds a held-word buffer so
//            stalls and same-doubleword advances issue no SRAM reads.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jb,
    input  logic [31:0] jb_addr,
    input  logic        stall,
    input  logic        isrv16,
    output logic        sram_cs,
    output logic [31:0] sram_addr,
    input  logic [63:0] sram_rdata,
    output logic [31:0] pc,
    output logic [63:0] instr,
    output logic        sram_cs_ff,
    output logic        jb_ff,
    output logic        instr_valid
);

    localparam logic [1:0] c_ST_RST   = 2'd0;
    localparam logic [1:0] c_ST_REQ   = 2'd1;
    localparam logic [1:0] c_ST_RUN   = 2'd2;
    localparam logic [1:0] c_ST_SPLIT = 2'd3;

`ifdef IFETCH_HOLD_BUF_EN
    localparam logic c_REFETCH = 1'b0;
`else
    // Without a held word the SRAM output is the only copy of the fetch word.
    localparam logic c_REFETCH = 1'b1;
`endif

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_pc;
    logic        r_cs_ff;
    logic        r_jb_ff;
    logic        r_redir;
    logic [28:0] w_dw;
    logic [31:0] w_next_pc;
    logic        w_complete;
    logic        w_adv;
    logic        w_cross;
    logic        w_jb_take;

    assign w_jb_take  = jb && (r_state != c_ST_RST);
    assign w_complete = isrv16 || (r_pc[2:1] != 2'b11);
    // A split instruction is always 32-bit, so SPLIT always steps by 4.
    assign w_next_pc  = r_pc + (((r_state == c_ST_SPLIT) || !isrv16) ? 32'd4 : 32'd2);
    assign w_cross    = (w_next_pc[31:3] != r_pc[31:3]);
    assign w_adv      = !stall && (((r_state == c_ST_RUN) && w_complete) ||
                                   (r_state == c_ST_SPLIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_RST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_RST:   w_state_nxt = c_ST_REQ;
            c_ST_REQ:   w_state_nxt = c_ST_RUN;
            c_ST_RUN:   if (!w_complete) w_state_nxt = c_ST_SPLIT;
            c_ST_SPLIT: if (!stall) w_state_nxt = c_ST_RUN;
            default:    w_state_nxt = c_ST_RST;
        endcase
        if (w_jb_take) begin
            w_state_nxt = c_ST_REQ;
        end
    end

    // The read address always targets the doubleword presented next cycle.
    always_comb begin
        sram_cs     = 1'b0;
        w_dw        = r_pc[31:3];
        instr_valid = 1'b0;
        case (r_state)
            c_ST_REQ: sram_cs = 1'b1;
            c_ST_RUN: begin
                instr_valid = w_complete;
                if (!w_complete) begin
                    sram_cs = 1'b1;
                    w_dw    = r_pc[31:3] + 29'd1;
                end else if (!stall) begin
                    sram_cs = w_cross | c_REFETCH;
                    w_dw    = w_next_pc[31:3];
                end else begin
                    sram_cs = c_REFETCH;
                end
            end
            c_ST_SPLIT: begin
                instr_valid = 1'b1;
                sram_cs     = c_REFETCH;
                w_dw        = r_pc[31:3] + 29'd1;
            end
            default: ;
        endcase
        if (rst || w_jb_take) begin
            sram_cs = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC & ~32'd1;
            r_cs_ff <= 1'b0;
            r_jb_ff <= 1'b0;
            r_redir <= 1'b0;
        end else begin
            r_cs_ff <= sram_cs;
            r_jb_ff <= (r_state == c_ST_REQ) && r_redir && !w_jb_take;
            if (w_jb_take) begin
                r_pc    <= jb_addr & ~32'd1;
                r_redir <= 1'b1;
            end else begin
                if (w_adv) begin
                    r_pc <= w_next_pc;
                end
                if (r_state == c_ST_REQ) begin
                    r_redir <= 1'b0;
                end
            end
        end
    end

`ifdef IFETCH_HOLD_BUF_EN
    logic [63:0] r_held;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_held <= '0;
        end else if (r_cs_ff) begin
            r_held <= sram_rdata;
        end
    end

    assign instr = r_cs_ff ? sram_rdata : r_held;
`else
    assign instr = sram_rdata;
`endif

    assign sram_addr  = {w_dw, 3'b000};
    assign pc         = r_pc;
    assign sram_cs_ff = r_cs_ff;
    assign jb_ff      = r_jb_ff;

endmodule

`default_nettype wire

// File: tb/tb_ifetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_seq
// Brief    : Directed self-checking bench for ifetch_seq with a 1-cycle SRAM
//            model; expectations adapt to IFETCH_HOLD_BUF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch_seq;

    localparam logic [31:0] c_RPC = 32'h0000_0100;
`ifdef IFETCH_HOLD_BUF_EN
    localparam logic c_HB = 1'b1;
`else
    localparam logic c_HB = 1'b0;
`endif
    // Expected sram_cs on cycles that need no new doubleword.
    localparam logic c_IDLE_CS = ~c_HB;

    logic        clk = 1'b0;
    logic        rst;
    logic        jb;
    logic [31:0] jb_addr;
    logic        stall;
    logic        isrv16;
    logic        sram_cs;
    logic [31:0] sram_addr;
    logic [63:0] sram_rdata;
    logic [31:0] pc;
    logic [63:0] instr;
    logic        sram_cs_ff;
    logic        jb_ff;
    logic        instr_valid;

    int n_total = 0;
    int n_bad   = 0;
    int n_fetch = 0;

    always #5 clk = ~clk;

    ifetch_seq #(.RESET_PC(c_RPC)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .jb          (jb),
        .jb_addr     (jb_addr),
        .stall       (stall),
        .isrv16      (isrv16),
        .sram_cs     (sram_cs),
        .sram_addr   (sram_addr),
        .sram_rdata  (sram_rdata),
        .pc          (pc),
        .instr       (instr),
        .sram_cs_ff  (sram_cs_ff),
        .jb_ff       (jb_ff),
        .instr_valid (instr_valid)
    );

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {32'h5A00_0000 ^ (a + 32'd4), 32'hC300_0000 ^ a};
    endfunction

    // Garbage on idle cycles exposes any use of stale SRAM output.
    always @(posedge clk) begin
        sram_rdata <= sram_cs ? mem_word(sram_addr) : 64'hDEAD_BEEF_DEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    // Leaves the DUT in its first RUN cycle at pc=c_RPC.
    task automatic restart;
        rst = 1'b1; jb = 1'b0; stall = 1'b0; isrv16 = 1'b0; jb_addr = '0;
        tick;
        rst = 1'b0;
        tick;
        tick;
    endtask

    initial begin
        rst = 1'b1; jb = 1'b0; stall = 1'b0; isrv16 = 1'b0; jb_addr = '0;
        tick; tick; settle;
        chk("rst_pc",    pc,          c_RPC);
        chk("rst_cs",    sram_cs,     1'b0);
        chk("rst_csff",  sram_cs_ff,  1'b0);
        chk("rst_jbff",  jb_ff,       1'b0);
        chk("rst_vld",   instr_valid, 1'b0);

        // 32-bit stream from reset
        rst = 1'b0;
        tick; settle;
        chk("a_req_cs",   sram_cs,     1'b1);
        chk("a_req_addr", sram_addr,   32'h100);
        chk("a_req_vld",  instr_valid, 1'b0);
        tick; settle;
        chk("a0_pc",    pc,          32'h100);
        chk("a0_vld",   instr_valid, 1'b1);
        chk("a0_instr", instr,       mem_word(32'h100));
        chk("a0_csff",  sram_cs_ff,  1'b1);
        chk("a0_cs",    sram_cs,     c_IDLE_CS);
        tick; settle;
        chk("a1_pc",    pc,        32'h104);
        chk("a1_instr", instr,     mem_word(32'h100));
        chk("a1_cs",    sram_cs,   1'b1);
        chk("a1_addr",  sram_addr, 32'h108);
        tick; settle;
        chk("a2_pc",    pc,         32'h108);
        chk("a2_instr", instr,      mem_word(32'h108));
        chk("a2_csff",  sram_cs_ff, 1'b1);

        // 16-bit stream, then a split 32-bit instruction at 0x10E
        restart;
        isrv16  = 1'b1;
        n_fetch = 0;
        for (int i = 0; i < 5; i++) begin
            settle;
            chk("b_pc",  pc,          c_RPC + 32'(2 * i));
            chk("b_vld", instr_valid, 1'b1);
            chk("b_cs",  sram_cs,     (i == 3) ? 1'b1 : c_IDLE_CS);
            if (i == 3) chk("b_addr", sram_addr, 32'h108);
            if (i < 4) n_fetch += int'(sram_cs);
            tick;
        end
        chk("b_fetches", n_fetch, c_HB ? 1 : 4);
        tick; tick; settle;
        isrv16 = 1'b0;
        settle;
        chk("c_pc",   pc,          32'h10E);
        chk("c_vld",  instr_valid, 1'b0);
        chk("c_cs",   sram_cs,     1'b1);
        chk("c_addr", sram_addr,   32'h110);
        tick; settle;
        chk("c_sp_pc",    pc,          32'h10E);
        chk("c_sp_vld",   instr_valid, 1'b1);
        chk("c_sp_instr", instr,       mem_word(32'h110));
        chk("c_sp_cs",    sram_cs,     c_IDLE_CS);
        tick; settle;
        chk("c_nx_pc",    pc,          32'h112);
        chk("c_nx_vld",   instr_valid, 1'b1);
        chk("c_nx_instr", instr,       mem_word(32'h110));
        chk("c_nx_csff",  sram_cs_ff,  c_IDLE_CS);
        chk("c_nx_cs",    sram_cs,     c_IDLE_CS);

        // Stall for 3 cycles at 0x104, then redirect while stalled
        restart;
        tick;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle;
            chk("d_pc",    pc,          32'h104);
            chk("d_instr", instr,       mem_word(32'h100));
            chk("d_vld",   instr_valid, 1'b1);
            chk("d_cs",    sram_cs,     c_IDLE_CS);
            tick;
        end
        jb = 1'b1; jb_addr = 32'h0000_2006;
        settle;
        chk("e_jb_cs", sram_cs, 1'b0);
        tick;
        jb = 1'b0; stall = 1'b0; isrv16 = 1'b1;
        settle;
        chk("e_req_cs",   sram_cs,     1'b1);
        chk("e_req_addr", sram_addr,   32'h2000);
        chk("e_req_vld",  instr_valid, 1'b0);
        chk("e_req_pc",   pc,          32'h2006);
        tick; settle;
        chk("e_run_jbff",  jb_ff,       1'b1);
        chk("e_run_pc",    pc,          32'h2006);
        chk("e_run_vld",   instr_valid, 1'b1);
        chk("e_run_instr", instr,       mem_word(32'h2000));
        chk("e_run_cs",    sram_cs,     1'b1);
        chk("e_run_addr",  sram_addr,   32'h2008);
        tick; settle;
        chk("e_nx_jbff",  jb_ff, 1'b0);
        chk("e_nx_pc",    pc,    32'h2008);
        chk("e_nx_instr", instr, mem_word(32'h2008));

        // Reset while in SPLIT
        restart;
        isrv16 = 1'b1;
        for (int i = 0; i < 7; i++) tick;
        isrv16 = 1'b0;
        tick; settle;
        chk("f_split_pc",  pc,          32'h10E);
        chk("f_split_vld", instr_valid, 1'b1);
        rst = 1'b1;
        tick; settle;
        chk("f_rst_pc",   pc,          c_RPC);
        chk("f_rst_cs",   sram_cs,     1'b0);
        chk("f_rst_vld",  instr_valid, 1'b0);
        chk("f_rst_jbff", jb_ff,       1'b0);
        chk("f_rst_csff", sram_cs_ff,  1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
